// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the countdown timer controller.
package timer_pkg;

  localparam int MIN_W   = 7;
  localparam int SEC_W   = 6;
  localparam int SEC_MAX = 59;

  // set_field codes shown on the mode indicators
  localparam logic [1:0] SET_NONE = 2'b00;
  localparam logic [1:0] SET_MIN  = 2'b01;
  localparam logic [1:0] SET_SEC  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SET_MIN = 3'd1,
    ST_SET_SEC = 3'd2,
    ST_RUN     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_ALARM   = 3'd5
  } tstate_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// Front-panel buttons, seconds-counter handshake and display/indicator bus.
interface timer_ctrl_if;
  import timer_pkg::*;

  logic             btn_ss;
  logic             btn_set;
  logic             btn_inc;
  logic             sec_p;
  logic             cnt_enable;
  logic             cnt_clear;
  logic [MIN_W-1:0] disp_min;
  logic [SEC_W-1:0] disp_sec;
  logic [1:0]       set_field;
  logic             alarm;
  logic [2:0]       state_o;

  // panel / seconds-counter side
  modport master (
    output btn_ss, btn_set, btn_inc, sec_p,
    input  cnt_enable, cnt_clear, disp_min, disp_sec, set_field, alarm, state_o
  );

  // timer controller side
  modport slave (
    input  btn_ss, btn_set, btn_inc, sec_p,
    output cnt_enable, cnt_clear, disp_min, disp_sec, set_field, alarm, state_o
  );

endinterface

// File: rtl/timer_ctrl_mmss_dec.sv
// Combinational mm:ss one-second decrement, saturating at 00:00, with zero detect on the result.
module mmss_dec
  import timer_pkg::*;
(
  input  logic [MIN_W-1:0] min_i,
  input  logic [SEC_W-1:0] sec_i,
  output logic [MIN_W-1:0] min_o,
  output logic [SEC_W-1:0] sec_o,
  output logic             zero_o
);

  // borrow from minutes when seconds are already zero; 00:00 stays 00:00
  always_comb begin
    min_o = min_i;
    sec_o = sec_i;
    if (sec_i != '0) begin
      sec_o = sec_i - SEC_W'(1);
    end else if (min_i != '0) begin
      min_o = min_i - MIN_W'(1);
      sec_o = SEC_W'(SEC_MAX);
    end
  end

  assign zero_o = (min_o == '0) && (sec_o == '0);

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: preset editing, run/pause countdown, timed alarm.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int MAX_MIN   = 99,
  parameter int DEF_MIN   = 3,
  parameter int DEF_SEC   = 0,
  parameter int ALARM_SEC = 10
) (
  input  logic         mclk,
  input  logic         rst,
  timer_ctrl_if.slave  bus
);

  localparam int ACNT_W = 8;

  tstate_t          state_q, state_d;
  logic [MIN_W-1:0] preset_min_q, preset_min_d;
  logic [SEC_W-1:0] preset_sec_q, preset_sec_d;
  logic [MIN_W-1:0] remain_min_q, remain_min_d;
  logic [SEC_W-1:0] remain_sec_q, remain_sec_d;
  logic [ACNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
  logic             clear_evt;

  logic             cnt_enable_q, cnt_enable_d;
  logic             cnt_clear_q, cnt_clear_d;
  logic             alarm_q, alarm_d;
  logic [1:0]       set_field_q, set_field_d;
  logic [MIN_W-1:0] disp_min_q, disp_min_d;
  logic [SEC_W-1:0] disp_sec_q, disp_sec_d;

  logic             win_ss, win_set, win_inc, any_btn;
  logic [MIN_W-1:0] dec_min;
  logic [SEC_W-1:0] dec_sec;
  logic             dec_zero;

  // only the highest-priority button pulse in a cycle is acted on
  assign win_ss  = bus.btn_ss;
  assign win_set = bus.btn_set & ~bus.btn_ss;
  assign win_inc = bus.btn_inc & ~bus.btn_ss & ~bus.btn_set;
  assign any_btn = bus.btn_ss | bus.btn_set | bus.btn_inc;

  mmss_dec u_dec (
    .min_i  (remain_min_q),
    .sec_i  (remain_sec_q),
    .min_o  (dec_min),
    .sec_o  (dec_sec),
    .zero_o (dec_zero)
  );

  // state and datapath registers
  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      preset_min_q <= MIN_W'(DEF_MIN);
      preset_sec_q <= SEC_W'(DEF_SEC);
      remain_min_q <= MIN_W'(DEF_MIN);
      remain_sec_q <= SEC_W'(DEF_SEC);
      alarm_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      preset_min_q <= preset_min_d;
      preset_sec_q <= preset_sec_d;
      remain_min_q <= remain_min_d;
      remain_sec_q <= remain_sec_d;
      alarm_cnt_q  <= alarm_cnt_d;
    end
  end

  // next state, preset/remain updates and clear requests
  always_comb begin
    state_d      = state_q;
    preset_min_d = preset_min_q;
    preset_sec_d = preset_sec_q;
    remain_min_d = remain_min_q;
    remain_sec_d = remain_sec_q;
    alarm_cnt_d  = alarm_cnt_q;
    clear_evt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_ss) begin
          if ((preset_min_q != '0) || (preset_sec_q != '0)) begin
            remain_min_d = preset_min_q;
            remain_sec_d = preset_sec_q;
            clear_evt    = 1'b1;
            state_d      = ST_RUN;
          end
        end else if (win_set) begin
          state_d = ST_SET_MIN;
        end
      end
      ST_SET_MIN: begin
        if (win_set) begin
          state_d = ST_SET_SEC;
        end else if (win_inc) begin
          preset_min_d = (preset_min_q == MIN_W'(MAX_MIN)) ? '0 : preset_min_q + MIN_W'(1);
        end
      end
      ST_SET_SEC: begin
        if (win_set) begin
          state_d = ST_IDLE;
        end else if (win_inc) begin
          preset_sec_d = (preset_sec_q == SEC_W'(SEC_MAX)) ? '0 : preset_sec_q + SEC_W'(1);
        end
      end
      ST_RUN: begin
        // a tick landing with start/stop is still counted; reaching zero beats the pause
        if (bus.sec_p) begin
          remain_min_d = dec_min;
          remain_sec_d = dec_sec;
        end
        if (bus.sec_p && dec_zero) begin
          alarm_cnt_d = '0;
          state_d     = ST_ALARM;
        end else if (win_ss) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        // resume keeps the counter's partial second, abort clears it
        if (win_ss) begin
          state_d = ST_RUN;
        end else if (win_set) begin
          clear_evt = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_ALARM: begin
        if (any_btn) begin
          clear_evt = 1'b1;
          state_d   = ST_IDLE;
        end else if (bus.sec_p) begin
          if (alarm_cnt_q + ACNT_W'(1) == ACNT_W'(ALARM_SEC)) begin
            alarm_cnt_d = '0;
            clear_evt   = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            alarm_cnt_d = alarm_cnt_q + ACNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs decoded from the next-state values so they appear right after the deciding edge
  always_comb begin
    cnt_enable_d = (state_d == ST_RUN) || (state_d == ST_ALARM);
    cnt_clear_d  = clear_evt;
    alarm_d      = (state_d == ST_ALARM);
    set_field_d  = SET_NONE;
    disp_min_d   = preset_min_d;
    disp_sec_d   = preset_sec_d;
    case (state_d)
      ST_SET_MIN: set_field_d = SET_MIN;
      ST_SET_SEC: set_field_d = SET_SEC;
      ST_RUN, ST_PAUSE: begin
        disp_min_d = remain_min_d;
        disp_sec_d = remain_sec_d;
      end
      ST_ALARM: begin
        disp_min_d = '0;
        disp_sec_d = '0;
      end
      default: ;
    endcase
  end

  // output registers
  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt_enable_q <= 1'b0;
      cnt_clear_q  <= 1'b0;
      alarm_q      <= 1'b0;
      set_field_q  <= SET_NONE;
      disp_min_q   <= MIN_W'(DEF_MIN);
      disp_sec_q   <= SEC_W'(DEF_SEC);
    end else begin
      cnt_enable_q <= cnt_enable_d;
      cnt_clear_q  <= cnt_clear_d;
      alarm_q      <= alarm_d;
      set_field_q  <= set_field_d;
      disp_min_q   <= disp_min_d;
      disp_sec_q   <= disp_sec_d;
    end
  end

  assign bus.cnt_enable = cnt_enable_q;
  assign bus.cnt_clear  = cnt_clear_q;
  assign bus.alarm      = alarm_q;
  assign bus.set_field  = set_field_q;
  assign bus.disp_min   = disp_min_q;
  assign bus.disp_sec   = disp_sec_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: vector table, directed corner sequences, randomized run vs. reference model.
module tb_timer_ctrl;
  import timer_pkg::*;

  localparam int MAX_MIN   = 99;
  localparam int DEF_MIN   = 3;
  localparam int DEF_SEC   = 0;
  localparam int ALARM_SEC = 10;

  logic mclk;
  logic rst;
  timer_ctrl_if bus ();

  timer_ctrl #(
    .MAX_MIN   (MAX_MIN),
    .DEF_MIN   (DEF_MIN),
    .DEF_SEC   (DEF_SEC),
    .ALARM_SEC (ALARM_SEC)
  ) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: preset as separate fields, remaining time as total seconds
  tstate_t m_mode;
  int      pm, ps, m_rem, m_ticks;
  logic    m_clr;

  typedef struct {
    logic    ss, set, inc, sp;
    tstate_t st;
    logic    en, clr, al;
    logic [1:0] fld;
    int      mn, sc;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [20:0] mk(tstate_t st, logic en, logic clr, logic al,
                                     logic [1:0] fld, int mn, int sc);
    logic [6:0] m7;
    logic [5:0] s6;
    m7 = 7'(mn);
    s6 = 6'(sc);
    return {st, en, clr, al, fld, m7, s6};
  endfunction

  function automatic logic [20:0] act_pack();
    return {bus.state_o, bus.cnt_enable, bus.cnt_clear, bus.alarm, bus.set_field,
            bus.disp_min, bus.disp_sec};
  endfunction

  function automatic logic [20:0] model_pack();
    logic [1:0] fld;
    int mn, sc;
    fld = (m_mode == ST_SET_MIN) ? 2'b01 : (m_mode == ST_SET_SEC) ? 2'b10 : 2'b00;
    if (m_mode == ST_RUN || m_mode == ST_PAUSE) begin
      mn = m_rem / 60;
      sc = m_rem % 60;
    end else if (m_mode == ST_ALARM) begin
      mn = 0;
      sc = 0;
    end else begin
      mn = pm;
      sc = ps;
    end
    return mk(m_mode, (m_mode == ST_RUN || m_mode == ST_ALARM), m_clr,
              (m_mode == ST_ALARM), fld, mn, sc);
  endfunction

  task automatic chk(input string name, input logic [20:0] exp);
    logic [20:0] act;
    act = act_pack();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got st=%0d en=%b clr=%b al=%b fld=%b %0d:%0d want st=%0d en=%b clr=%b al=%b fld=%b %0d:%0d",
               name, cyc, act[20:18], act[17], act[16], act[15], act[14:13], act[12:6], act[5:0],
               exp[20:18], exp[17], exp[16], exp[15], exp[14:13], exp[12:6], exp[5:0]);
    end
  endtask

  task automatic model_reset();
    m_mode  = ST_IDLE;
    pm      = DEF_MIN;
    ps      = DEF_SEC;
    m_rem   = DEF_MIN * 60 + DEF_SEC;
    m_ticks = 0;
    m_clr   = 1'b0;
  endtask

  task automatic model_step(input logic ss, input logic set, input logic inc, input logic sp);
    logic w_set, w_inc;
    w_set = set && !ss;
    w_inc = inc && !ss && !set;
    m_clr = 1'b0;
    case (m_mode)
      ST_IDLE: begin
        if (ss) begin
          if (pm * 60 + ps != 0) begin
            m_rem  = pm * 60 + ps;
            m_clr  = 1'b1;
            m_mode = ST_RUN;
          end
        end else if (w_set) m_mode = ST_SET_MIN;
      end
      ST_SET_MIN: begin
        if (w_set) m_mode = ST_SET_SEC;
        else if (w_inc) pm = (pm + 1) % (MAX_MIN + 1);
      end
      ST_SET_SEC: begin
        if (w_set) m_mode = ST_IDLE;
        else if (w_inc) ps = (ps + 1) % 60;
      end
      ST_RUN: begin
        if (sp) m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_mode  = ST_ALARM;
          m_ticks = 0;
        end else if (ss) m_mode = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (ss) m_mode = ST_RUN;
        else if (w_set) begin
          m_clr  = 1'b1;
          m_mode = ST_IDLE;
        end
      end
      ST_ALARM: begin
        if (ss || set || inc) begin
          m_clr  = 1'b1;
          m_mode = ST_IDLE;
        end else if (sp) begin
          m_ticks++;
          if (m_ticks == ALARM_SEC) begin
            m_clr  = 1'b1;
            m_mode = ST_IDLE;
          end
        end
      end
      default: m_mode = ST_IDLE;
    endcase
  endtask

  // one clock of stimulus, checked against the model
  task automatic step(input logic ss, input logic set, input logic inc, input logic sp);
    @(negedge mclk);
    bus.btn_ss  = ss;
    bus.btn_set = set;
    bus.btn_inc = inc;
    bus.sec_p   = sp;
    @(posedge mclk);
    #1;
    cyc++;
    model_step(ss, set, inc, sp);
    $display("cyc %0d ss=%b set=%b inc=%b sp=%b -> st=%0d %0d:%0d en=%b clr=%b al=%b fld=%b",
             cyc, ss, set, inc, sp, bus.state_o, bus.disp_min, bus.disp_sec,
             bus.cnt_enable, bus.cnt_clear, bus.alarm, bus.set_field);
    chk("model", model_pack());
  endtask

  task automatic do_reset();
    @(negedge mclk);
    rst         = 1'b1;
    bus.btn_ss  = 1'b0;
    bus.btn_set = 1'b0;
    bus.btn_inc = 1'b0;
    bus.sec_p   = 1'b0;
    @(posedge mclk);
    #1;
    cyc++;
    model_reset();
    $display("cyc %0d reset -> st=%0d %0d:%0d", cyc, bus.state_o, bus.disp_min, bus.disp_sec);
    chk("reset", mk(ST_IDLE, 1'b0, 1'b0, 1'b0, 2'b00, 3, 0));
    rst = 1'b0;
  endtask

  task automatic repeat_step(input int n, input logic inc, input logic sp);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, inc, sp);
  endtask

  initial begin
    rst         = 1'b1;
    bus.btn_ss  = 1'b0;
    bus.btn_set = 1'b0;
    bus.btn_inc = 1'b0;
    bus.sec_p   = 1'b0;
    model_reset();

    // ss set inc sp | state en clr al fld min sec  (starts from reset, preset 03:00)
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, ST_RUN,     1'b1, 1'b1, 1'b0, 2'b00, 3, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, ST_RUN,     1'b1, 1'b0, 1'b0, 2'b00, 3, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, ST_RUN,     1'b1, 1'b0, 1'b0, 2'b00, 2, 59};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, ST_RUN,     1'b1, 1'b0, 1'b0, 2'b00, 2, 59};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, ST_RUN,     1'b1, 1'b0, 1'b0, 2'b00, 2, 58};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, ST_PAUSE,   1'b0, 1'b0, 1'b0, 2'b00, 2, 58};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, ST_PAUSE,   1'b0, 1'b0, 1'b0, 2'b00, 2, 58};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, ST_RUN,     1'b1, 1'b0, 1'b0, 2'b00, 2, 58};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, ST_PAUSE,   1'b0, 1'b0, 1'b0, 2'b00, 2, 57};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE,    1'b0, 1'b1, 1'b0, 2'b00, 3, 0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, ST_SET_MIN, 1'b0, 1'b0, 1'b0, 2'b01, 3, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, ST_SET_MIN, 1'b0, 1'b0, 1'b0, 2'b01, 4, 0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_SET_MIN, 1'b0, 1'b0, 1'b0, 2'b01, 4, 0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, ST_SET_SEC, 1'b0, 1'b0, 1'b0, 2'b10, 4, 0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, ST_SET_SEC, 1'b0, 1'b0, 1'b0, 2'b10, 4, 1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE,    1'b0, 1'b0, 1'b0, 2'b00, 4, 1};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b0, ST_RUN,     1'b1, 1'b1, 1'b0, 2'b00, 4, 1};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_PAUSE,   1'b0, 1'b0, 1'b0, 2'b00, 4, 1};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE,    1'b0, 1'b1, 1'b0, 2'b00, 4, 1};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].ss, vecs[i].set, vecs[i].inc, vecs[i].sp);
      chk($sformatf("vec%0d", i), mk(vecs[i].st, vecs[i].en, vecs[i].clr, vecs[i].al,
                                     vecs[i].fld, vecs[i].mn, vecs[i].sc));
    end

    // preset 00:02 -> alarm after two ticks, alarm lasts ten ticks
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat_step(97, 1'b1, 1'b0);
    chk("min_to_zero", mk(ST_SET_MIN, 1'b0, 1'b0, 1'b0, 2'b01, 0, 0));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat_step(2, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("preset_0002", mk(ST_IDLE, 1'b0, 1'b0, 1'b0, 2'b00, 0, 2));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_0002", mk(ST_RUN, 1'b1, 1'b1, 1'b0, 2'b00, 0, 2));
    repeat_step(2, 1'b0, 1'b1);
    chk("alarm_on", mk(ST_ALARM, 1'b1, 1'b0, 1'b1, 2'b00, 0, 0));
    repeat_step(9, 1'b0, 1'b1);
    chk("alarm_9", mk(ST_ALARM, 1'b1, 1'b0, 1'b1, 2'b00, 0, 0));
    repeat_step(1, 1'b0, 1'b1);
    chk("alarm_end", mk(ST_IDLE, 1'b0, 1'b1, 1'b0, 2'b00, 0, 2));
    repeat_step(1, 1'b0, 1'b0);
    chk("alarm_clr_drop", mk(ST_IDLE, 1'b0, 1'b0, 1'b0, 2'b00, 0, 2));

    // RUN at 01:00 with start/stop and tick together
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat_step(1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat_step(58, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("preset_0100", mk(ST_IDLE, 1'b0, 1'b0, 1'b0, 2'b00, 1, 0));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("ss_with_tick", mk(ST_PAUSE, 1'b0, 1'b0, 1'b0, 2'b00, 0, 59));
    repeat_step(1, 1'b0, 1'b1);
    chk("pause_tick", mk(ST_PAUSE, 1'b0, 1'b0, 1'b0, 2'b00, 0, 59));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume", mk(ST_RUN, 1'b1, 1'b0, 1'b0, 2'b00, 0, 59));
    repeat_step(22, 1'b0, 1'b1);
    chk("run_0037", mk(ST_RUN, 1'b1, 1'b0, 1'b0, 2'b00, 0, 37));
    do_reset();

    // preset wrap: 99 minute presses and 60 second presses
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat_step(99, 1'b1, 1'b0);
    chk("min_wrap", mk(ST_SET_MIN, 1'b0, 1'b0, 1'b0, 2'b01, 2, 0));
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat_step(60, 1'b1, 1'b0);
    chk("sec_wrap", mk(ST_SET_SEC, 1'b0, 1'b0, 1'b0, 2'b10, 2, 0));
    step(1'b0, 1'b1, 1'b0, 1'b0);

    // zero preset: start is ignored
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat_step(98, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero_start", mk(ST_IDLE, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0));

    // alarm left early with a button
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat_step(1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat_step(60, 1'b0, 1'b1);
    chk("alarm_0100", mk(ST_ALARM, 1'b1, 1'b0, 1'b1, 2'b00, 0, 0));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("alarm_btn_exit", mk(ST_IDLE, 1'b0, 1'b1, 1'b0, 2'b00, 1, 0));

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
